// File: rtl/bkm_e_iter.sv
// BKM E-mode iteration engine: E converges to E0*exp(L0) while L is driven toward zero,
// using an external ln(1 + d*2^-n) table addressed by (n, dx, dy).
module bkm_e_iter #(
  parameter int W      = 32,
  parameter int N_ITER = 24,
  parameter int NB     = 5
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          enable,
  input  logic          start,
  input  logic [W-1:0]  ex_i,
  input  logic [W-1:0]  ey_i,
  input  logic [W-1:0]  lx_i,
  input  logic [W-1:0]  ly_i,
  output logic [NB-1:0] tbl_n,
  output logic [1:0]    tbl_dx,
  output logic [1:0]    tbl_dy,
  input  logic [W-1:0]  tbl_re,
  input  logic [W-1:0]  tbl_im,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  ex_o,
  output logic [W-1:0]  ey_o,
  output logic [W-1:0]  lx_o,
  output logic [W-1:0]  ly_o
);

  // lambda is held in sixteenths; width covers L shifted left by up to 2^NB+3 without loss
  localparam int WL  = W + (1 << NB) + 4;
  localparam int WT  = W + 2;
  localparam int NBP = NB + 1;
  localparam logic [NB-1:0]        N_LAST   = NB'(N_ITER);
  localparam logic signed [WL-1:0] LAM_X_LO = WL'(-8);
  localparam logic signed [WL-1:0] LAM_X_HI = WL'(4);
  localparam logic signed [WL-1:0] LAM_Y_LO = WL'(-12);
  localparam logic signed [WL-1:0] LAM_Y_HI = WL'(12);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_next;
  logic [NB-1:0]          n;
  logic signed [W-1:0]    ex, ey, lx, ly;
  logic [NBP-1:0]         lam_sh;
  logic signed [WL-1:0]   lx_wide, ly_wide, lam_x, lam_y;
  logic [1:0]             dx, dy;
  logic signed [WT-1:0]   ex_w, ey_w, term_x, term_y;
  logic [W-1:0]           ex_next, ey_next, lx_next, ly_next;

  function automatic logic signed [WT-1:0] scale_by_digit(input logic [1:0] d,
                                                          input logic signed [WT-1:0] v);
    case (d)
      2'b01:   return v;
      2'b11:   return -v;
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (srst)        state <= IDLE;
    else if (enable) state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (n == N_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    tbl_dx = 2'b00;
    tbl_dy = 2'b00;
    case (state)
      RUN: begin
        busy   = 1'b1;
        tbl_dx = dx;
        tbl_dy = dy;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign tbl_n = n;

  // floor(2^n * L * 16) via an exact left shift followed by an arithmetic right shift
  always_comb begin
    lam_sh  = {1'b0, n} + NBP'(4);
    lx_wide = {{(WL-W){lx[W-1]}}, lx};
    ly_wide = {{(WL-W){ly[W-1]}}, ly};
    lam_x   = (lx_wide <<< lam_sh) >>> (W - 2);
    lam_y   = (ly_wide <<< lam_sh) >>> (W - 2);

    if (lam_x < LAM_X_LO)      dx = 2'b11;
    else if (lam_x > LAM_X_HI) dx = 2'b01;
    else                       dx = 2'b00;

    if (lam_y < LAM_Y_LO)      dy = 2'b11;
    else if (lam_y > LAM_Y_HI) dy = 2'b01;
    else                       dy = 2'b00;

    ex_w    = {{2{ex[W-1]}}, ex};
    ey_w    = {{2{ey[W-1]}}, ey};
    term_x  = scale_by_digit(dx, ex_w) - scale_by_digit(dy, ey_w);
    term_y  = scale_by_digit(dx, ey_w) + scale_by_digit(dy, ex_w);
    ex_next = W'(ex_w + (term_x >>> n));
    ey_next = W'(ey_w + (term_y >>> n));
    lx_next = lx - tbl_re;
    ly_next = ly - tbl_im;
  end

  // The result registers only change on the last iteration, so they hold through IDLE
  always_ff @(posedge clk) begin
    if (srst) begin
      n    <= '0;
      ex   <= '0;
      ey   <= '0;
      lx   <= '0;
      ly   <= '0;
      ex_o <= '0;
      ey_o <= '0;
      lx_o <= '0;
      ly_o <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            ex <= ex_i;
            ey <= ey_i;
            lx <= lx_i;
            ly <= ly_i;
            n  <= NB'(1);
          end
        end
        RUN: begin
          ex <= ex_next;
          ey <= ey_next;
          lx <= lx_next;
          ly <= ly_next;
          n  <= n + NB'(1);
          if (n == N_LAST) begin
            ex_o <= ex_next;
            ey_o <= ey_next;
            lx_o <= lx_next;
            ly_o <= ly_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
